// File: rtl/soc_system_sysid_pkg.sv
// Shared system-ID constants and checker state encoding.
// Constants are the single source for software headers, the sysid slave and the checker.
// No datapath, so no latency or backpressure.
package soc_system_sysid_pkg;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'hACD5_1302;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h5909_D49C;

  typedef enum logic [2:0] {
    ST_SETTLE,
    ST_RD_ID,
    ST_WAIT_ID,
    ST_RD_TS,
    ST_WAIT_TS,
    ST_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/soc_system_sysid_checker.sv
// Reads sysid ID/timestamp words and checks them against build constants, with bounded retries.
// Latency: SETTLE_CYCLES + 3 + 2*READ_LATENCY cycles per attempt until done.
// Backpressure: none; the slave is assumed to answer every read after READ_LATENCY cycles.
module soc_system_sysid_checker
  import soc_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID   = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS   = DEFAULT_EXPECTED_TS,
  parameter bit          CHECK_TS      = 1'b1,
  parameter int unsigned READ_LATENCY  = 0,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned RETRY_MAX     = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [1:0]  retry_count
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LAT_LOAD    = 8'((READ_LATENCY > 0) ? (READ_LATENCY - 1) : 0);
  localparam logic [1:0] RETRY_LIM   = 2'(RETRY_MAX);
  localparam bit         LAT_ZERO    = (READ_LATENCY == 0);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        done_nxt, pass_nxt, fail_nxt;
  logic [1:0]  retry_nxt;
  logic [31:0] id_nxt, ts_nxt;
  logic        match;

  // Strobes decode straight from state so a reset drops them without waiting for an edge.
  assign sysid_read    = (state == ST_RD_ID) || (state == ST_RD_TS);
  assign sysid_address = (state == ST_RD_TS) || (state == ST_WAIT_TS);

  assign match = (id_value == EXPECTED_ID) && (!CHECK_TS || (ts_value == EXPECTED_TS));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_SETTLE;
      cnt         <= 8'd0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      retry_count <= 2'd0;
      id_value    <= 32'd0;
      ts_value    <= 32'd0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      done        <= done_nxt;
      pass        <= pass_nxt;
      fail        <= fail_nxt;
      retry_count <= retry_nxt;
      id_value    <= id_nxt;
      ts_value    <= ts_nxt;
    end
  end

  // cnt counts up through SETTLE (cleared on entry) and down through the read-latency waits.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = done;
    pass_nxt  = pass;
    fail_nxt  = fail;
    retry_nxt = retry_count;
    id_nxt    = id_value;
    ts_nxt    = ts_value;
    case (state)
      ST_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_nxt   = 8'd0;
          state_nxt = ST_RD_ID;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      ST_RD_ID: begin
        if (LAT_ZERO) begin
          id_nxt    = sysid_readdata;
          state_nxt = ST_RD_TS;
        end else begin
          cnt_nxt   = LAT_LOAD;
          state_nxt = ST_WAIT_ID;
        end
      end
      ST_WAIT_ID: begin
        if (cnt == 8'd0) begin
          id_nxt    = sysid_readdata;
          state_nxt = ST_RD_TS;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      ST_RD_TS: begin
        if (LAT_ZERO) begin
          ts_nxt    = sysid_readdata;
          state_nxt = ST_CHECK;
        end else begin
          cnt_nxt   = LAT_LOAD;
          state_nxt = ST_WAIT_TS;
        end
      end
      ST_WAIT_TS: begin
        if (cnt == 8'd0) begin
          ts_nxt    = sysid_readdata;
          state_nxt = ST_CHECK;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      ST_CHECK: begin
        if (match) begin
          pass_nxt  = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = ST_DONE;
        end else if (retry_count < RETRY_LIM) begin
          retry_nxt = retry_count + 2'd1;
          cnt_nxt   = 8'd0;
          state_nxt = ST_SETTLE;
        end else begin
          fail_nxt  = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          fail_nxt  = 1'b0;
          retry_nxt = 2'd0;
          cnt_nxt   = 8'd0;
          state_nxt = ST_SETTLE;
        end
      end
      default: begin
        cnt_nxt   = 8'd0;
        state_nxt = ST_SETTLE;
      end
    endcase
  end

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Bench for soc_system_sysid_checker: three parameterisations driven by behavioural sysid slaves.
module tb_soc_system_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'hACD5_1302;
  localparam logic [31:0] EXP_TS = 32'h5909_D49C;
  localparam logic [31:0] BAD_ID = 32'h1234_5678;
  localparam logic [31:0] BAD_TS = 32'h0000_BEEF;
  localparam logic [31:0] JUNK   = 32'h0BAD_F00D;

  typedef struct {
    int          cyc;
    logic        pass;
    logic        fail;
    logic [1:0]  retry;
    logic [31:0] id;
    logic [31:0] ts;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  // ---------------- base instance: defaults, latency 0 ----------------
  logic        base_start = 1'b0;
  logic        base_addr, base_read, base_done, base_pass, base_fail;
  logic [31:0] base_rdata, base_id, base_ts;
  logic [1:0]  base_retry;
  int          base_bad = 0;
  int          base_reads;

  soc_system_sysid_checker u_base (
    .clock(clock), .reset_n(reset_n), .start(base_start),
    .sysid_address(base_addr), .sysid_read(base_read), .sysid_readdata(base_rdata),
    .done(base_done), .pass(base_pass), .fail(base_fail),
    .id_value(base_id), .ts_value(base_ts), .retry_count(base_retry)
  );

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) base_reads <= 0;
    else if (base_read && !base_addr) base_reads <= base_reads + 1;
  end
  always_comb begin
    base_rdata = JUNK;
    if (base_read) base_rdata = base_addr ? EXP_TS : ((base_reads < base_bad) ? BAD_ID : EXP_ID);
  end

  // ---------------- timestamp-ignored instance ----------------
  logic        nots_start = 1'b0;
  logic        nots_addr, nots_read, nots_done, nots_pass, nots_fail;
  logic [31:0] nots_rdata, nots_id, nots_ts;
  logic [1:0]  nots_retry;

  soc_system_sysid_checker #(.CHECK_TS(1'b0)) u_nots (
    .clock(clock), .reset_n(reset_n), .start(nots_start),
    .sysid_address(nots_addr), .sysid_read(nots_read), .sysid_readdata(nots_rdata),
    .done(nots_done), .pass(nots_pass), .fail(nots_fail),
    .id_value(nots_id), .ts_value(nots_ts), .retry_count(nots_retry)
  );

  always_comb begin
    nots_rdata = JUNK;
    if (nots_read) nots_rdata = nots_addr ? BAD_TS : EXP_ID;
  end

  // ---------------- latency-2 instance ----------------
  logic        lat_start = 1'b0;
  logic        lat_addr, lat_read, lat_done, lat_pass, lat_fail;
  logic [31:0] lat_rdata, lat_id, lat_ts;
  logic [1:0]  lat_retry;
  int          lat_bad = 0;
  int          lat_reads;
  logic        p1_vld, p2_vld;
  logic [31:0] p1_dat, p2_dat;

  soc_system_sysid_checker #(.READ_LATENCY(2)) u_lat (
    .clock(clock), .reset_n(reset_n), .start(lat_start),
    .sysid_address(lat_addr), .sysid_read(lat_read), .sysid_readdata(lat_rdata),
    .done(lat_done), .pass(lat_pass), .fail(lat_fail),
    .id_value(lat_id), .ts_value(lat_ts), .retry_count(lat_retry)
  );

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_reads <= 0;
      p1_vld <= 1'b0; p2_vld <= 1'b0; p1_dat <= '0; p2_dat <= '0;
    end else begin
      p1_vld <= lat_read;
      p1_dat <= lat_addr ? EXP_TS : ((lat_reads < lat_bad) ? BAD_ID : EXP_ID);
      p2_vld <= p1_vld;
      p2_dat <= p1_dat;
      if (lat_read && !lat_addr) lat_reads <= lat_reads + 1;
    end
  end
  assign lat_rdata = p2_vld ? p2_dat : JUNK;

  // ---------------- helpers ----------------
  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic wait_cycle(input int c);
    for (int i = 0; i < 1000 && cyc < c; i++) @(negedge clock);
  endtask

  task automatic base_wait_and_check(input string name);
    for (int i = 0; i < 300 && base_done !== 1'b1; i++) @(negedge clock);
    e = sb.pop_front();
    n_checks++; if (base_done !== 1'b1) begin n_fail++; $display("FAIL %s_timeout: done=%b want 1", name, base_done); end
    n_checks++; if (cyc !== e.cyc) begin n_fail++; $display("FAIL %s_cycle: got %0d want %0d", name, cyc, e.cyc); end
    n_checks++; if (base_pass !== e.pass) begin n_fail++; $display("FAIL %s_pass: got %b want %b", name, base_pass, e.pass); end
    n_checks++; if (base_fail !== e.fail) begin n_fail++; $display("FAIL %s_fail: got %b want %b", name, base_fail, e.fail); end
    n_checks++; if (base_retry !== e.retry) begin n_fail++; $display("FAIL %s_retry: got %0d want %0d", name, base_retry, e.retry); end
    n_checks++; if (base_id !== e.id) begin n_fail++; $display("FAIL %s_id: got %h want %h", name, base_id, e.id); end
    n_checks++; if (base_ts !== e.ts) begin n_fail++; $display("FAIL %s_ts: got %h want %h", name, base_ts, e.ts); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++; if ({base_read, base_addr, base_done, base_pass, base_fail} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 00000", {base_read, base_addr, base_done, base_pass, base_fail}); end
    n_checks++; if ({base_id, base_ts, base_retry} !== 66'd0) begin
      n_fail++; $display("FAIL reset_data: id=%h ts=%h retry=%0d want zeros", base_id, base_ts, base_retry); end
    reset_n = 1'b1;
  endtask

  task automatic test_pass();
    base_bad = 0;
    do_reset();
    sb.push_back('{cyc: 19, pass: 1'b1, fail: 1'b0, retry: 2'd0, id: EXP_ID, ts: EXP_TS});
    wait_cycle(16);
    n_checks++; if ({base_read, base_addr} !== 2'b10) begin n_fail++; $display("FAIL pass_rd_id: read/addr=%b want 10", {base_read, base_addr}); end
    wait_cycle(17);
    n_checks++; if ({base_read, base_addr} !== 2'b11) begin n_fail++; $display("FAIL pass_rd_ts: read/addr=%b want 11", {base_read, base_addr}); end
    wait_cycle(18);
    n_checks++; if (base_done !== 1'b0) begin n_fail++; $display("FAIL pass_early: done=%b want 0 at cycle 18", base_done); end
    base_start = 1'b1;  // lands on the CHECK->DONE edge and must be ignored
    base_wait_and_check("pass");
    base_start = 1'b0;
    @(negedge clock);
    n_checks++; if (base_done !== 1'b1 || base_read !== 1'b0) begin
      n_fail++; $display("FAIL pass_hold: done=%b read=%b want 1 0", base_done, base_read); end
  endtask

  task automatic test_retry_pass();
    base_bad = 2;
    do_reset();
    sb.push_back('{cyc: 57, pass: 1'b1, fail: 1'b0, retry: 2'd2, id: EXP_ID, ts: EXP_TS});
    base_wait_and_check("retry");
  endtask

  task automatic test_fail();
    base_bad = 100;
    do_reset();
    sb.push_back('{cyc: 76, pass: 1'b0, fail: 1'b1, retry: 2'd3, id: BAD_ID, ts: EXP_TS});
    base_wait_and_check("fail");
  endtask

  task automatic test_ts_ignored();
    do_reset();
    sb.push_back('{cyc: 19, pass: 1'b1, fail: 1'b0, retry: 2'd0, id: EXP_ID, ts: BAD_TS});
    for (int i = 0; i < 300 && nots_done !== 1'b1; i++) @(negedge clock);
    e = sb.pop_front();
    n_checks++; if (cyc !== e.cyc) begin n_fail++; $display("FAIL nots_cycle: got %0d want %0d", cyc, e.cyc); end
    n_checks++; if (nots_pass !== e.pass || nots_fail !== e.fail) begin
      n_fail++; $display("FAIL nots_result: pass=%b fail=%b want %b %b", nots_pass, nots_fail, e.pass, e.fail); end
    n_checks++; if (nots_ts !== e.ts) begin n_fail++; $display("FAIL nots_ts: got %h want %h", nots_ts, e.ts); end
  endtask

  task automatic test_latency();
    int s;
    lat_bad = 1;
    do_reset();
    sb.push_back('{cyc: 46, pass: 1'b1, fail: 1'b0, retry: 2'd1, id: EXP_ID, ts: EXP_TS});
    wait_cycle(10);
    lat_start = 1'b1;
    @(negedge clock);
    lat_start = 1'b0;
    wait_cycle(16);
    n_checks++; if ({lat_read, lat_addr} !== 2'b10) begin n_fail++; $display("FAIL lat_strobe_id: read/addr=%b want 10", {lat_read, lat_addr}); end
    wait_cycle(18);
    n_checks++; if (lat_id !== 32'd0 || lat_read !== 1'b0) begin n_fail++; $display("FAIL lat_id_early: id=%h read=%b want 0 0", lat_id, lat_read); end
    wait_cycle(19);
    n_checks++; if (lat_id !== BAD_ID) begin n_fail++; $display("FAIL lat_id_capture: got %h want %h", lat_id, BAD_ID); end
    n_checks++; if ({lat_read, lat_addr} !== 2'b11) begin n_fail++; $display("FAIL lat_strobe_ts: read/addr=%b want 11", {lat_read, lat_addr}); end
    wait_cycle(21);
    n_checks++; if (lat_ts !== 32'd0 || lat_addr !== 1'b1) begin n_fail++; $display("FAIL lat_ts_early: ts=%h addr=%b want 0 1", lat_ts, lat_addr); end
    wait_cycle(22);
    n_checks++; if (lat_ts !== EXP_TS) begin n_fail++; $display("FAIL lat_ts_capture: got %h want %h", lat_ts, EXP_TS); end
    n_checks++; if (lat_done !== 1'b0) begin n_fail++; $display("FAIL lat_first_done: done=%b want 0 (retry expected)", lat_done); end
    for (int i = 0; i < 300 && lat_done !== 1'b1; i++) @(negedge clock);
    e = sb.pop_front();
    n_checks++; if (cyc !== e.cyc) begin n_fail++; $display("FAIL lat_cycle: got %0d want %0d", cyc, e.cyc); end
    n_checks++; if (lat_pass !== e.pass || lat_retry !== e.retry) begin
      n_fail++; $display("FAIL lat_result: pass=%b retry=%0d want %b %0d", lat_pass, lat_retry, e.pass, e.retry); end
    // rerun from DONE: outputs clear on the start edge, captured words stay
    repeat (3) @(negedge clock);
    s = cyc;
    sb.push_back('{cyc: s + 24, pass: 1'b1, fail: 1'b0, retry: 2'd0, id: EXP_ID, ts: EXP_TS});
    lat_start = 1'b1;
    @(negedge clock);
    lat_start = 1'b0;
    n_checks++; if ({lat_done, lat_pass, lat_fail, lat_retry} !== 5'b0) begin
      n_fail++; $display("FAIL lat_start_clear: done/pass/fail/retry=%b want 00000", {lat_done, lat_pass, lat_fail, lat_retry}); end
    n_checks++; if (lat_id !== EXP_ID) begin n_fail++; $display("FAIL lat_id_kept: got %h want %h", lat_id, EXP_ID); end
    for (int i = 0; i < 300 && lat_done !== 1'b1; i++) @(negedge clock);
    e = sb.pop_front();
    n_checks++; if (cyc !== e.cyc) begin n_fail++; $display("FAIL lat_rerun_cycle: got %0d want %0d", cyc, e.cyc); end
    n_checks++; if (lat_pass !== e.pass || lat_retry !== e.retry) begin
      n_fail++; $display("FAIL lat_rerun_result: pass=%b retry=%0d want %b %0d", lat_pass, lat_retry, e.pass, e.retry); end
  endtask

  task automatic test_reset_mid();
    base_bad = 0;
    do_reset();
    wait_cycle(17);
    n_checks++; if ({base_read, base_addr} !== 2'b11) begin n_fail++; $display("FAIL mid_in_rd_ts: read/addr=%b want 11", {base_read, base_addr}); end
    reset_n = 1'b0;
    #1;
    n_checks++; if ({base_read, base_addr, base_done, base_pass, base_fail} !== 5'b0) begin
      n_fail++; $display("FAIL mid_async_ctrl: got %b want 00000", {base_read, base_addr, base_done, base_pass, base_fail}); end
    n_checks++; if ({base_id, base_ts, base_retry} !== 66'd0) begin
      n_fail++; $display("FAIL mid_async_data: id=%h ts=%h retry=%0d want zeros", base_id, base_ts, base_retry); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    sb.push_back('{cyc: 19, pass: 1'b1, fail: 1'b0, retry: 2'd0, id: EXP_ID, ts: EXP_TS});
    base_wait_and_check("mid_rerun");
  endtask

  initial begin
    test_reset();
    test_pass();
    test_retry_pass();
    test_fail();
    test_ts_ignored();
    test_latency();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
